// File: rtl/mem_stage.sv
// Memory-access stage: latches one instruction from execute, collects the load response, extracts
// and extends the load lane, and hands the result to write-back. Build with MEM_STAGE_FWD_EN to get the decode bypass port.
module mem_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        es_to_ms_valid,
    output logic        ms_allowin,
    input  logic [31:0] es_pc,
    input  logic [31:0] es_alu_result,
    input  logic [4:0]  es_rf_waddr,
    input  logic        es_rf_we,
    input  logic        es_mem_re,
    input  logic [2:0]  es_ld_op,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        ws_allowin,
    output logic        ms_to_ws_valid,
    output logic [31:0] ms_pc,
    output logic [31:0] ms_rf_wdata,
    output logic [4:0]  ms_rf_waddr,
    output logic        ms_rf_we,
    output logic        ms_fwd_valid,
    output logic [4:0]  ms_fwd_waddr,
    output logic [31:0] ms_fwd_wdata,
    output logic        ms_fwd_stall
);

    // state   | meaning
    // S_EMPTY | no instruction held
    // S_WAIT  | load held, response not yet seen
    // S_BUF   | load held, response parked in rdata_buf_q (write-back was stalled)
    // S_DONE  | non-load held, ready for write-back
    typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_BUF, S_DONE} state_t;

    state_t      state_q, state_d, entry_state;
    logic [31:0] pc_q, pc_d;
    logic [31:0] alu_q, alu_d;
    logic [4:0]  waddr_q, waddr_d;
    logic        we_q, we_d;
    logic        mem_re_q, mem_re_d;
    logic [2:0]  ld_op_q, ld_op_d;
    logic [1:0]  addr_q, addr_d;
    logic [31:0] rdata_buf_q, rdata_buf_d;

    logic        ms_valid, buf_valid, ready_go, accept;
    logic [31:0] ld_word, ld_data;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign ms_valid    = (state_q != S_EMPTY);
    assign buf_valid   = (state_q == S_BUF);
    assign ready_go    = !mem_re_q || buf_valid || data_sram_data_ok;
    assign ms_allowin  = !ms_valid || (ready_go && ws_allowin);
    assign accept      = es_to_ms_valid && ms_allowin;
    assign entry_state = es_mem_re ? S_WAIT : S_DONE;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_EMPTY;
            pc_q        <= 32'd0;
            alu_q       <= 32'd0;
            waddr_q     <= 5'd0;
            we_q        <= 1'b0;
            mem_re_q    <= 1'b0;
            ld_op_q     <= 3'd0;
            addr_q      <= 2'd0;
            rdata_buf_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            alu_q       <= alu_d;
            waddr_q     <= waddr_d;
            we_q        <= we_d;
            mem_re_q    <= mem_re_d;
            ld_op_q     <= ld_op_d;
            addr_q      <= addr_d;
            rdata_buf_q <= rdata_buf_d;
        end
    end

    // A response with write-back open passes straight through: WAIT->DONE and the handoff share one edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: begin
                if (es_to_ms_valid)
                    state_d = entry_state;
            end
            S_WAIT: begin
                if (data_sram_data_ok) begin
                    if (!ws_allowin)
                        state_d = S_BUF;
                    else
                        state_d = es_to_ms_valid ? entry_state : S_EMPTY;
                end
            end
            S_BUF, S_DONE: begin
                if (ws_allowin)
                    state_d = es_to_ms_valid ? entry_state : S_EMPTY;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        pc_d        = pc_q;
        alu_d       = alu_q;
        waddr_d     = waddr_q;
        we_d        = we_q;
        mem_re_d    = mem_re_q;
        ld_op_d     = ld_op_q;
        addr_d      = addr_q;
        rdata_buf_d = rdata_buf_q;
        if (accept) begin
            pc_d     = es_pc;
            alu_d    = es_alu_result;
            waddr_d  = es_rf_waddr;
            we_d     = es_rf_we;
            mem_re_d = es_mem_re;
            ld_op_d  = es_ld_op;
            addr_d   = es_alu_result[1:0];
        end
        if (state_q == S_WAIT && data_sram_data_ok && !ws_allowin)
            rdata_buf_d = data_sram_rdata;
    end

    always_comb begin
        ld_word = buf_valid ? rdata_buf_q : data_sram_rdata;
        case (addr_q)
            2'd0:    lane_b = ld_word[7:0];
            2'd1:    lane_b = ld_word[15:8];
            2'd2:    lane_b = ld_word[23:16];
            default: lane_b = ld_word[31:24];
        endcase
        lane_h = addr_q[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_op_q)
            3'b001:  ld_data = {{24{lane_b[7]}}, lane_b};
            3'b010:  ld_data = {{16{lane_h[15]}}, lane_h};
            3'b011:  ld_data = {24'd0, lane_b};
            3'b100:  ld_data = {16'd0, lane_h};
            default: ld_data = ld_word;
        endcase
        ms_to_ws_valid = ms_valid && ready_go;
        ms_pc          = pc_q;
        ms_rf_waddr    = waddr_q;
        ms_rf_we       = we_q;
        ms_rf_wdata    = mem_re_q ? ld_data : alu_q;
    end

`ifdef MEM_STAGE_FWD_EN
    assign ms_fwd_valid = ms_valid && we_q && (waddr_q != 5'd0);
    assign ms_fwd_waddr = waddr_q;
    assign ms_fwd_wdata = ms_rf_wdata;
    assign ms_fwd_stall = ms_valid && mem_re_q && !ready_go;
`else
    assign ms_fwd_valid = 1'b0;
    assign ms_fwd_waddr = 5'd0;
    assign ms_fwd_wdata = 32'd0;
    assign ms_fwd_stall = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus random traffic against a transaction-level model
// of the single-entry stage. Honours MEM_STAGE_FWD_EN for the bypass port expectations.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        es_to_ms_valid;
    logic        ms_allowin;
    logic [31:0] es_pc;
    logic [31:0] es_alu_result;
    logic [4:0]  es_rf_waddr;
    logic        es_rf_we;
    logic        es_mem_re;
    logic [2:0]  es_ld_op;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc;
    logic [31:0] ms_rf_wdata;
    logic [4:0]  ms_rf_waddr;
    logic        ms_rf_we;
    logic        ms_fwd_valid;
    logic [4:0]  ms_fwd_waddr;
    logic [31:0] ms_fwd_wdata;
    logic        ms_fwd_stall;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .es_to_ms_valid    (es_to_ms_valid),
        .ms_allowin        (ms_allowin),
        .es_pc             (es_pc),
        .es_alu_result     (es_alu_result),
        .es_rf_waddr       (es_rf_waddr),
        .es_rf_we          (es_rf_we),
        .es_mem_re         (es_mem_re),
        .es_ld_op          (es_ld_op),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_pc             (ms_pc),
        .ms_rf_wdata       (ms_rf_wdata),
        .ms_rf_waddr       (ms_rf_waddr),
        .ms_rf_we          (ms_rf_we),
        .ms_fwd_valid      (ms_fwd_valid),
        .ms_fwd_waddr      (ms_fwd_waddr),
        .ms_fwd_wdata      (ms_fwd_wdata),
        .ms_fwd_stall      (ms_fwd_stall)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: the one instruction the stage holds, and the load data it already owns (if any).
    logic        m_valid, m_have;
    logic [31:0] m_pc, m_alu, m_data;
    logic [4:0]  m_waddr;
    logic        m_we, m_re;
    logic [2:0]  m_op;

    logic        obs_valid, obs_allowin, obs_stall;
    logic [31:0] obs_pc, obs_wdata;

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] a, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * a)) & 32'h0000_00FF;
        h = (w >> (16 * a[1])) & 32'h0000_FFFF;
        case (op)
            3'd1:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'd2:    return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd3:    return b;
            3'd4:    return h;
            default: return w;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0; m_have = 0; m_pc = 0; m_alu = 0; m_data = 0;
        m_waddr = 0; m_we = 0; m_re = 0; m_op = 0;
    endtask

    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] wa,
                        input logic we, input logic re, input logic [2:0] op,
                        input logic dok, input logic [31:0] rd, input logic wsa);
        logic        rg, handoff;
        logic [31:0] exp_wd;
        @(negedge clk);
        es_to_ms_valid = v; es_pc = pc; es_alu_result = alu; es_rf_waddr = wa;
        es_rf_we = we; es_mem_re = re; es_ld_op = op;
        data_sram_data_ok = dok; data_sram_rdata = rd; ws_allowin = wsa;
        #1;
        obs_valid = ms_to_ws_valid; obs_allowin = ms_allowin; obs_stall = ms_fwd_stall;
        obs_pc = ms_pc; obs_wdata = ms_rf_wdata;
        rg      = m_valid && (!m_re || m_have || dok);
        handoff = rg && wsa;
        exp_wd  = m_re ? ref_load(m_op, m_alu[1:0], m_have ? m_data : rd) : m_alu;
        check("allowin", ms_allowin, !m_valid || handoff);
        check("to_ws_valid", ms_to_ws_valid, rg);
        if (rg) begin
            check("pc", ms_pc, m_pc);
            check("wdata", ms_rf_wdata, exp_wd);
            check("waddr", ms_rf_waddr, m_waddr);
            check("we", ms_rf_we, m_we);
        end
`ifdef MEM_STAGE_FWD_EN
        check("fwd_valid", ms_fwd_valid, m_valid && m_we && (m_waddr != 5'd0));
        check("fwd_stall", ms_fwd_stall, m_valid && m_re && !rg);
        if (m_valid) check("fwd_waddr", ms_fwd_waddr, m_waddr);
        if (rg) check("fwd_wdata", ms_fwd_wdata, exp_wd);
`else
        check("fwd_tied", {ms_fwd_valid, ms_fwd_stall, ms_fwd_waddr, ms_fwd_wdata[24:0]}, 32'd0);
`endif
        @(posedge clk);
        if (v && (!m_valid || handoff)) begin
            m_valid = 1; m_have = 0; m_pc = pc; m_alu = alu; m_waddr = wa;
            m_we = we; m_re = re; m_op = op;
        end else if (handoff) begin
            m_valid = 0; m_have = 0;
        end else if (m_valid && m_re && !m_have && dok) begin
            m_have = 1; m_data = rd;
        end
    endtask

    task automatic idle(input logic dok, input logic [31:0] rd, input logic wsa);
        step(0, 32'h0, 32'h0, 5'd0, 0, 0, 3'd0, dok, rd, wsa);
    endtask

    // Accept a load, leave `gap` empty cycles, then deliver the response with write-back open.
    task automatic do_load(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rd, input int gap);
        step(1, 32'h1c00_0100, addr, 5'd7, 1, 1, op, 0, 32'h0, 1);
        for (int i = 0; i < gap; i++) begin
            idle(0, 32'hDEAD_BEEF, 1);
            check("ld_wait_valid", obs_valid, 0);
`ifdef MEM_STAGE_FWD_EN
            check("ld_wait_stall", obs_stall, 1);
`endif
        end
        idle(1, rd, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, ms_to_ws_valid, 0);
        check({tag, "_allowin"}, ms_allowin, 1);
        check({tag, "_pc"}, ms_pc, 0);
        check({tag, "_wdata"}, ms_rf_wdata, 0);
        check({tag, "_waddr_we"}, {ms_rf_waddr, ms_rf_we}, 0);
        check({tag, "_fwd"}, {ms_fwd_valid, ms_fwd_stall, ms_fwd_waddr, ms_fwd_wdata[24:0]}, 0);
        check({tag, "_fwd_wdata"}, ms_fwd_wdata, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 0; es_to_ms_valid = 0; es_pc = 0; es_alu_result = 0; es_rf_waddr = 0;
        es_rf_we = 0; es_mem_re = 0; es_ld_op = 0; data_sram_data_ok = 0;
        data_sram_rdata = 0; ws_allowin = 1;
        model_reset();
        #1;
        check_reset_outputs("rst0");
        repeat (2) @(negedge clk);
        resetn = 1;

        // ALU instruction: one cycle through the stage
        step(1, 32'h1c00_0000, 32'h0000_1234, 5'd5, 1, 0, 3'd0, 0, 32'h0, 1);
        idle(0, 32'h0, 1);
        check("add_valid", obs_valid, 1);
        check("add_wdata", obs_wdata, 32'h0000_1234);
        idle(0, 32'h0, 1);
        check("add_gone", obs_valid, 0);

        do_load(3'd1, 32'h0000_1003, 32'h80FF_7F01, 2);
        check("ld_b", obs_wdata, 32'hFFFF_FF80);
        do_load(3'd3, 32'h0000_1003, 32'h80FF_7F01, 0);
        check("ld_bu", obs_wdata, 32'h0000_0080);
        do_load(3'd2, 32'h0000_2002, 32'h8001_1234, 0);
        check("ld_h", obs_wdata, 32'hFFFF_8001);
        do_load(3'd4, 32'h0000_2002, 32'h8001_1234, 1);
        check("ld_hu", obs_wdata, 32'h0000_8001);
        do_load(3'd0, 32'h0000_2000, 32'h8001_1234, 0);
        check("ld_w", obs_wdata, 32'h8001_1234);
        do_load(3'd1, 32'h0000_2001, 32'h0000_8000, 0);
        check("ld_b_lane1", obs_wdata, 32'hFFFF_FF80);

        // Response lands while write-back is stalled; the bus then carries garbage
        step(1, 32'h1c00_0200, 32'h0000_3000, 5'd9, 1, 1, 3'd0, 0, 32'h0, 1);
        idle(1, 32'hCAFE_F00D, 0);
        check("buf_first_valid", obs_valid, 1);
        check("buf_first_allowin", obs_allowin, 0);
        for (int i = 0; i < 4; i++) begin
            idle(0, $urandom, 0);
            check("buf_hold_allowin", obs_allowin, 0);
            check("buf_hold_wdata", obs_wdata, 32'hCAFE_F00D);
        end
        idle(1, $urandom, 1);
        check("buf_deliver", obs_wdata, 32'hCAFE_F00D);
        idle(0, 32'h0, 1);
        check("buf_once", obs_valid, 0);

        // Back-to-back stream of ALU instructions
        for (int i = 0; i < 5; i++) begin
            if (i < 4) step(1, 32'h1c00_1000 + 4 * i, 32'h100 + i, 5'(i + 1), 1, 0, 3'd0, 0, 32'h0, 1);
            else       idle(0, 32'h0, 1);
            if (i > 0) begin
                check("stream_valid", obs_valid, 1);
                check("stream_pc", obs_pc, 32'h1c00_1000 + 4 * (i - 1));
            end
        end

        // Asynchronous reset while a load waits, then a stray response
        step(1, 32'h1c00_3000, 32'h0000_4000, 5'd3, 1, 1, 3'd0, 0, 32'h0, 1);
        idle(0, 32'h0, 1);
        @(negedge clk);
        #2 resetn = 0;
        #1;
        check_reset_outputs("rst_mid");
        model_reset();
        @(negedge clk);
        resetn = 1;
        idle(1, 32'h1234_5678, 1);
        check("stray_ok", obs_valid, 0);
        idle(0, 32'h0, 1);
        check("stray_after", obs_valid, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 2) != 0, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                 3'($urandom_range(0, 7)), $urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
